// File: rtl/shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shifter_pkg
// Description : Operation encodings and helpers shared by the pipelined shifter.
// Revision    : 1.0 - initial release
// ============================================================================
package shifter_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_SLL = 3'b000;
    localparam mode_t MODE_SRL = 3'b001;
    localparam mode_t MODE_SRA = 3'b010;
    localparam mode_t MODE_ROL = 3'b011;
    localparam mode_t MODE_ROR = 3'b100;

    function automatic logic is_right(input mode_t mode);
        return (mode == MODE_SRL) || (mode == MODE_SRA) || (mode == MODE_ROR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_stage
// Description : One shift layer (fixed distance SHIFT_AMT) plus its pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_stage
    import shifter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SHIFT_AMT   = 1,
    parameter int unsigned TAG_WIDTH   = 4,
    parameter int unsigned SHAMT_WIDTH = 5,
    parameter int unsigned STAGE_IDX   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    input  logic                   i_valid,
    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic [SHAMT_WIDTH-1:0] i_shamt,
    input  mode_t                  i_mode,
    input  logic [TAG_WIDTH-1:0]   i_tag,
    output logic                   o_valid,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic [SHAMT_WIDTH-1:0] o_shamt,
    output mode_t                  o_mode,
    output logic [TAG_WIDTH-1:0]   o_tag
);

    logic [DATA_WIDTH-1:0]  w_sll;
    logic [DATA_WIDTH-1:0]  w_srl;
    logic [DATA_WIDTH-1:0]  w_sra;
    logic [DATA_WIDTH-1:0]  w_rol;
    logic [DATA_WIDTH-1:0]  w_ror;
    logic [DATA_WIDTH-1:0]  w_result;

    logic                   r_valid;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [SHAMT_WIDTH-1:0] r_shamt;
    mode_t                  r_mode;
    logic [TAG_WIDTH-1:0]   r_tag;

    assign w_sll = i_data << SHIFT_AMT;
    assign w_srl = i_data >> SHIFT_AMT;
    assign w_sra = $signed(i_data) >>> SHIFT_AMT;
    // Rotates reuse the zero-fill shifts and OR back the bits pushed off the far end.
    assign w_rol = w_sll | (i_data >> (DATA_WIDTH - SHIFT_AMT));
    assign w_ror = w_srl | (i_data << (DATA_WIDTH - SHIFT_AMT));

    always_comb begin
        w_result = i_data;
        if (i_shamt[STAGE_IDX]) begin
            case (i_mode)
                MODE_SLL: w_result = w_sll;
                MODE_SRL: w_result = w_srl;
                MODE_SRA: w_result = w_sra;
                MODE_ROL,
                MODE_ROR: w_result = is_right(i_mode) ? w_ror : w_rol;
                default:  w_result = i_data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_shamt <= '0;
            r_mode  <= MODE_SLL;
            r_tag   <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_data  <= w_result;
            r_shamt <= i_shamt;
            r_mode  <= i_mode;
            r_tag   <= i_tag;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_shamt = r_shamt;
    assign o_mode  = r_mode;
    assign o_tag   = r_tag;

endmodule
`default_nettype wire

// File: rtl/pipelined_shifter.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_shifter
// Description : Log-depth pipelined barrel shifter/rotator, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH),
    parameter int unsigned TAG_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [SHAMT_WIDTH-1:0] in_shamt,
    input  logic [2:0]             in_mode,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [TAG_WIDTH-1:0]   out_tag
);

    logic                   w_stall;
    logic                   w_en;

    // Index k is the input of stage k; index SHAMT_WIDTH is the last register bank.
    logic                   w_valid [SHAMT_WIDTH+1];
    logic [DATA_WIDTH-1:0]  w_data  [SHAMT_WIDTH+1];
    logic [SHAMT_WIDTH-1:0] w_shamt [SHAMT_WIDTH+1];
    mode_t                  w_mode  [SHAMT_WIDTH+1];
    logic [TAG_WIDTH-1:0]   w_tag   [SHAMT_WIDTH+1];

    assign w_stall  = out_valid & ~out_ready;
    assign w_en     = ~w_stall;
    assign in_ready = ~w_stall;

    assign w_valid[0] = in_valid & in_ready;
    assign w_data[0]  = in_data;
    assign w_shamt[0] = in_shamt;
    assign w_mode[0]  = in_mode;
    assign w_tag[0]   = in_tag;

    for (genvar k = 0; k < SHAMT_WIDTH; k++) begin : g_stage
        shift_stage #(
            .DATA_WIDTH  (DATA_WIDTH),
            .SHIFT_AMT   (2 ** k),
            .TAG_WIDTH   (TAG_WIDTH),
            .SHAMT_WIDTH (SHAMT_WIDTH),
            .STAGE_IDX   (k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_en    (w_en),
            .i_valid (w_valid[k]),
            .i_data  (w_data[k]),
            .i_shamt (w_shamt[k]),
            .i_mode  (w_mode[k]),
            .i_tag   (w_tag[k]),
            .o_valid (w_valid[k+1]),
            .o_data  (w_data[k+1]),
            .o_shamt (w_shamt[k+1]),
            .o_mode  (w_mode[k+1]),
            .o_tag   (w_tag[k+1])
        );
    end

    assign out_valid = w_valid[SHAMT_WIDTH];
    assign out_data  = w_data[SHAMT_WIDTH];
    assign out_tag   = w_tag[SHAMT_WIDTH];

endmodule
`default_nettype wire
